// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Used by fetch_buf and fetch_unit.
package fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam int OPCODE_LSB = 2;
    localparam int FUNC3_LSB  = 12;
    localparam int FUNC7_LSB  = 25;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small FIFO of fetched {pc, inst} entries. The head is read straight from storage.
// Clear has priority over push and pop; push and pop in the same cycle are legal.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    localparam int PTR_W = $clog2(BUF_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    output fetch_entry_t       head,
    output logic [PTR_W:0]     count,
    output logic               full,
    output logic               empty
);

    fetch_entry_t     mem [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(BUF_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (do_push && !clear && !rst) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem requests, instruction buffer and field split for ctrl.
// Optional FETCH_MISALIGN_CHK_EN adds a sticky misalign flag that halts fetch on a bad redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int             XLEN      = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0,
    parameter int             BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [4:0]      opcode,
    output logic [2:0]      func3,
    output logic [6:0]      func7
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic            misalign
`endif
);

    localparam int PTR_W = $clog2(BUF_DEPTH);

    fetch_state_e     state;
    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  req_pc;
    logic             inflight;
    logic             halted;
    logic             push;
    logic             pop;
    logic             clear;
    fetch_entry_t     push_data;
    fetch_entry_t     head;
    logic [PTR_W:0]   buf_count;
    logic             buf_full;
    logic             buf_empty;
    logic [PTR_W+1:0] occ;
    logic             unused_sink;

    fetch_buf #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

`ifdef FETCH_MISALIGN_CHK_EN
    assign halted = misalign;
`else
    assign halted = 1'b0;
`endif

    assign unused_sink = buf_full ^ (^redirect_pc[1:0]);

    assign inst_valid = !buf_empty;
    assign pop        = inst_valid && !stall && !redirect;
    assign clear      = redirect && (state != IDLE);
    // A response arriving during FLUSH belongs to the old stream and is dropped.
    assign push       = inflight && (state == RUN);
    assign push_data  = '{pc: 32'(req_pc), inst: imem_rdata};
    assign occ        = {1'b0, buf_count} + (PTR_W+2)'(inflight);

    always_comb begin
        imem_req = 1'b0;
        if (state != IDLE) begin
            if (occ < (PTR_W+2)'(BUF_DEPTH))
                imem_req = 1'b1;
            else if (occ == (PTR_W+2)'(BUF_DEPTH) && pop)
                imem_req = 1'b1;
        end
    end

    assign imem_addr = fetch_pc;
    assign inst      = inst_valid ? head.inst : NOP_INST;
    assign inst_pc   = inst_valid ? XLEN'(head.pc) : PC_RESET;
    assign opcode    = inst[OPCODE_LSB +: 5];
    assign func3     = inst[FUNC3_LSB +: 3];
    assign func7     = inst[FUNC7_LSB +: 7];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= PC_RESET;
            inflight <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign <= 1'b0;
`endif
        end else begin
            inflight <= imem_req;
            case (state)
                IDLE: begin
                    if (!halted) state <= RUN;
                end
                default: begin
                    if (redirect) begin
`ifdef FETCH_MISALIGN_CHK_EN
                        if (redirect_pc[1:0] != 2'b00) begin
                            misalign <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
                            state    <= FLUSH;
                        end
`else
                        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
                        state    <= FLUSH;
`endif
                    end else begin
                        if (imem_req) fetch_pc <= fetch_pc + XLEN'(4);
                        state <= RUN;
                    end
                end
            endcase
        end
    end

    // Address of the outstanding request, paired with its data on return.
    always_ff @(posedge clk) begin
        if (imem_req) req_pc <= fetch_pc;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle synchronous memory returning {8'hA5, addr[23:0]}.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        misalign;
`endif

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.XLEN(32), .PC_RESET(32'h0), .BUF_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .opcode      (opcode),
        .func3       (func3),
        .func7       (func7)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .misalign    (misalign)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then apply this cycle's inputs and let outputs settle.
    task automatic cyc(input logic r_rst, input logic s, input logic r, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rst = r_rst; stall = s; redirect = r; redirect_pc = rpc;
        #1;
    endtask

    task automatic exp_inst(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
        chk({tag, "_pc"}, inst_pc, pc);
        chk({tag, "_inst"}, inst, mem_word(pc));
    endtask

    task automatic exp_empty(input string tag);
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, "_inst"}, inst, 32'h0000_0013);
        chk({tag, "_opcode"}, {27'd0, opcode}, 32'h4);
    endtask

    task automatic exp_req(input string tag, input logic [31:0] addr);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, "_addr"}, imem_addr, addr);
    endtask

    task automatic exp_reset(input string tag);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        exp_empty(tag);
        chk({tag, "_inst_pc"}, inst_pc, 32'h0);
        chk({tag, "_func3"}, {29'd0, func3}, 32'h0);
        chk({tag, "_func7"}, {25'd0, func7}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        exp_reset("reset");
        rst = 1'b0;
        #1;
        chk("c1_idle_req", {31'd0, imem_req}, 32'd0);
        cyc(0, 0, 0, 0);  exp_req("c2", 32'h0);  exp_empty("c2");
        cyc(0, 0, 0, 0);  exp_req("c3", 32'h4);  exp_empty("c3");
        cyc(0, 0, 0, 0);  exp_req("c4", 32'h8);  exp_inst("c4", 32'h0);
        chk("c4_opcode", {27'd0, opcode}, 32'h0);
        chk("c4_func7", {25'd0, func7}, 32'h52);
        cyc(0, 0, 0, 0);  exp_req("c5", 32'hC); exp_inst("c5", 32'h4);

        // Stall for five cycles with PC 8 at the head.
        cyc(0, 1, 0, 0);  exp_inst("st1", 32'h8);
        chk("st1_req", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0);
            exp_inst("st_hold", 32'h8);
            chk("st_hold_req", {31'd0, imem_req}, 32'd0);
        end
        cyc(0, 0, 0, 0);  exp_inst("rel1", 32'h8);  exp_req("rel1", 32'h10);
        cyc(0, 0, 0, 0);  exp_inst("rel2", 32'hC);  exp_req("rel2", 32'h14);
        cyc(0, 0, 0, 0);  exp_inst("rel3", 32'h10); exp_req("rel3", 32'h18);

        // Fill the buffer, then redirect to 0x40.
        cyc(0, 1, 0, 0);  exp_inst("fill", 32'h14);
        cyc(0, 0, 1, 32'h40);
        exp_inst("rd_cyc", 32'h14);
        chk("rd_cyc_req", {31'd0, imem_req}, 32'd0);
        cyc(0, 0, 0, 0);  exp_empty("rd_n1");  exp_req("rd_n1", 32'h40);
        cyc(0, 0, 0, 0);  exp_empty("rd_n2");  exp_req("rd_n2", 32'h44);
        cyc(0, 0, 0, 0);  exp_inst("rd_n3", 32'h40);
        chk("rd_n3_opcode", {27'd0, opcode}, 32'h10);
        cyc(0, 0, 0, 0);  exp_inst("rd_n4", 32'h44);

        // Redirect together with stall drops the held head.
        cyc(0, 1, 1, 32'h80);  exp_inst("rs_cyc", 32'h48);
        cyc(0, 0, 0, 0);  exp_empty("rs_n1");  exp_req("rs_n1", 32'h80);
        cyc(0, 0, 0, 0);  exp_empty("rs_n2");
        cyc(0, 0, 0, 0);  exp_inst("rs_n3", 32'h80);

        // Redirect during FLUSH restarts it with the newer target.
        cyc(0, 0, 1, 32'h100);  exp_inst("rf_cyc", 32'h84);
        cyc(0, 0, 1, 32'h200);  exp_empty("rf_n1");  exp_req("rf_n1", 32'h100);
        cyc(0, 0, 0, 0);  exp_empty("rf_n2");  exp_req("rf_n2", 32'h200);
        cyc(0, 0, 0, 0);  exp_empty("rf_n3");
        cyc(0, 0, 0, 0);  exp_inst("rf_n4", 32'h200);
        cyc(0, 0, 0, 0);  exp_inst("rf_n5", 32'h204); exp_req("rf_n5", 32'h20C);

        // Reset mid-stream with a response outstanding.
        cyc(1, 0, 0, 0);  exp_inst("mr_cyc", 32'h208);
        cyc(0, 0, 0, 0);  exp_reset("mr_n1");
        cyc(0, 0, 0, 0);  exp_req("mr_n2", 32'h0);  exp_empty("mr_n2");
        cyc(0, 0, 0, 0);  exp_empty("mr_n3");
        cyc(0, 0, 0, 0);  exp_inst("mr_n4", 32'h0);

        // Misaligned redirect target.
        cyc(0, 0, 1, 32'h42);  exp_inst("ma_cyc", 32'h4);
`ifdef FETCH_MISALIGN_CHK_EN
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0);
            chk("ma_flag", {31'd0, misalign}, 32'd1);
            chk("ma_req", {31'd0, imem_req}, 32'd0);
            exp_empty("ma_halt");
        end
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("ma_rst_flag", {31'd0, misalign}, 32'd0);
        chk("ma_rst_req", {31'd0, imem_req}, 32'd0);
        cyc(0, 0, 0, 0);  exp_req("ma_restart", 32'h0);
`else
        cyc(0, 0, 0, 0);  exp_empty("ma_n1");  exp_req("ma_n1", 32'h40);
        cyc(0, 0, 0, 0);  exp_empty("ma_n2");
        cyc(0, 0, 0, 0);  exp_inst("ma_n3", 32'h40);
        cyc(0, 0, 0, 0);  exp_inst("ma_n4", 32'h44);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of `ctrl`. Holds the fetch PC and issues reads to synchronous instruction memory. Buffers returned words in a small FIFO and presents the head instruction, with its `opcode`/`func3`/`func7` fields pre-split, to `ctrl` and the datapath. Obeys the stall and redirect requests that `ctrl` produces (load phase, taken branch, JAL/JALR).

## Interface
- `XLEN`, 32, PC/address width
- `PC_RESET`, 32'h0000_0000, first fetch address after reset
- `BUF_DEPTH`, 2, instruction buffer entries (power of two, ≥2)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `imem_req`  out  1  read strobe to instruction memory
- `imem_addr`  out  XLEN  word-aligned read address
- `imem_rdata`  in  32  read data, valid exactly 1 cycle after `imem_req`
- `stall`  in  1  hold head instruction (load phase / `next_nop` from `ctrl`)
- `redirect`  in  1  PC change requested (`pc_sel` ≠ PC+4)
- `redirect_pc`  in  XLEN  target of redirect
- `inst_valid`  out  1  head instruction valid
- `inst`  out  32  head instruction word (NOP when invalid)
- `inst_pc`  out  XLEN  PC of head instruction
- `opcode`  out  5  `inst[6:2]`
- `func3`  out  3  `inst[14:12]`
- `func7`  out  7  `inst[31:25]`
- `misalign`  out  1  only with `FETCH_MISALIGN_CHK_EN` (see Configuration)

## Operation
- FSM states: IDLE, RUN, FLUSH.
  - IDLE: entered on reset, left after one cycle to RUN.
  - RUN: normal fetch.
  - FLUSH: one cycle after any redirect.
- Request rule in RUN/FLUSH: `imem_req`=1 when `count + inflight < BUF_DEPTH`, or when equal and a pop occurs this cycle. `imem_addr`=`fetch_pc`. On request, `fetch_pc += 4` (mod 2^XLEN, wraps silently).
- Response: `imem_rdata` is pushed with its PC one cycle after a request, unless the cycle is FLUSH. In FLUSH the stale response is discarded.
- Pop: occurs at the edge when `inst_valid && !stall && !redirect`.
- Redirect (any state except IDLE):
  - `fetch_pc` ← `redirect_pc` with bits [1:0] forced to 0.
  - Buffer cleared; state ← FLUSH.
  - Redirect has priority over stall, push and pop.
- Stall: the head and all outputs hold. Fetch continues until the buffer is full, then stops.
- Empty buffer: `inst_valid`=0, `inst`=NOP 32'h0000_0013. Fields are decoded from the NOP (`opcode`=5'b00100).

## Timing
- Reset values:
  - `fetch_pc`=`PC_RESET`, `count`=0, `inflight`=0, state=IDLE.
  - `imem_req`=0, `inst_valid`=0, `inst`=NOP, `inst_pc`=`PC_RESET`.
  - `opcode`=5'b00100, `func3`=0, `func7`=0.
- After `rst` falls:
  - cycle 1: IDLE.
  - cycle 2: `imem_req`=1 at `PC_RESET`.
  - cycle 3: data pushed.
  - cycle 4: `inst_valid`=1.
  - Steady state: one instruction per cycle.
- Redirect latency: `redirect` sampled at edge N.
  - Cycle N+1: FLUSH, `inst_valid`=0, request at target.
  - Cycle N+2: target data pushed.
  - Cycle N+3: target instruction valid (3-cycle bubble).
- Simultaneous push and pop with full buffer: allowed, `count` unchanged.
- Redirect while `stall`=1: flush still happens; stall is ignored for that cycle.
- Redirect during FLUSH: restarts FLUSH with the new target.
- `rst` mid-operation: all state returns to reset values at that edge. Any outstanding response is discarded.
- Outputs are registered or derived only from the registered buffer head. No combinational path from `imem_rdata` to outputs.

## Configuration
- `FETCH_MISALIGN_CHK_EN` defined:
  - Adds port `misalign`.
  - `redirect` with `redirect_pc[1:0]`≠0 sets `misalign`=1 (sticky until `rst`).
  - State ← IDLE and fetch halts: no `imem_req`, `inst_valid`=0.
- Not defined: no `misalign` port; bits [1:0] are silently cleared.

## Structure
- `fetch_pkg`:
  - `NOP_INST` constant.
  - FSM state enum (IDLE/RUN/FLUSH).
  - Field bit-position constants (`OPCODE_LSB`=2, `FUNC3_LSB`=12, `FUNC7_LSB`=25).
  - `fetch_entry_t` struct {pc, inst}.
- Sub-module `fetch_buf`: `BUF_DEPTH`-entry FIFO of `fetch_entry_t` with push, pop, clear, count, full and empty. Simultaneous push+pop is legal.
- Top level holds the FSM, `fetch_pc`, the inflight flag and field split.

## Test plan
- Reset release, no stall, memory returning addr-based words:
  - `imem_addr` sequence 0,4,8,…
  - first `inst_valid` on cycle 4 with `inst_pc`=0.
  - then one instruction per cycle.
- Hold `stall`=1 for 5 cycles with instruction at PC 8 on head:
  - outputs are frozen.
  - `imem_req` drops once `count`=2.
  - after release, PCs 8,C,10 emerge in order with no loss or duplicates.
- `redirect`=1, `redirect_pc`=0x40 while buffer is full:
  - next cycle `inst_valid`=0, `inst`=0x13, `opcode`=5'b00100, `imem_addr`=0x40.
  - PC 0x40 is valid 3 cycles after redirect.
  - the stale response is never presented.
- `redirect` and `stall` both 1 in the same cycle: flush occurs and the old head is dropped.
- Assert `rst` 2 cycles after a request: next cycle all outputs equal reset values, and the pending response is discarded.
- With `FETCH_MISALIGN_CHK_EN`, `redirect_pc`=0x42: `misalign`=1, `imem_req` stays 0 until `rst`. Without the macro, fetch resumes at 0x40.
